// File: rtl/cdc_xfer_arb_pkg.sv
// Shared types and helpers for the clk_down crossing arbiter.
package cdc_xfer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping modulo NREQ) wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [IDW-1:0] j;

  // Scan from the farthest offset back to ptr so the closest request wins last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = |req;
    j          = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt_onehot    = '0;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = j;
      end
    end
  end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin scheduler sharing one fast-to-slow crossing among NREQ
// requesters. A granted word is held on xfer_data for HOLD_CYCLES, followed
// by GAP_CYCLES of idle, so the slow side always samples a settled word.
// Optional per-requester grant counters: define CDC_XFER_ARBITER_STATS_EN.
module cdc_xfer_arbiter
  import cdc_xfer_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         xfer_data,
  output logic [$clog2(NREQ)-1:0]  xfer_id,
  output logic                     xfer_active,
  output logic                     busy
`ifdef CDC_XFER_ARBITER_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   grant_cnt
`endif
);

  localparam int IDW     = id_width(NREQ);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t       state;
  logic [IDW-1:0]   rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             grant;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // A grant only happens in IDLE and never while reset is asserted.
  assign grant     = (state == IDLE) && pick_any && !reset;
  assign req_ready = grant ? pick_onehot : '0;

  // FSM, hold/gap counter, rotating pointer and registered crossing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      xfer_data   <= '0;
      xfer_id     <= '0;
      xfer_active <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            xfer_data   <= req_data[pick_idx*WIDTH +: WIDTH];
            xfer_id     <= pick_idx;
            rr_ptr      <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt         <= CNT_W'(HOLD_CYCLES - 1);
            xfer_active <= 1'b1;
            busy        <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            xfer_active <= 1'b0;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt   <= CNT_W'(GAP_CYCLES - 1);
              state <= GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          xfer_active <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef CDC_XFER_ARBITER_STATS_EN
  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (grant) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pick_onehot[i] && (grant_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
          grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: directed scenarios plus random requester
// traffic, checked every cycle against a grant-time reference model.
module tb_cdc_xfer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int HOLD  = 16;
  localparam int GAP   = 2;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid,  req_valid0;
  logic [NREQ*WIDTH-1:0]   req_data,   req_data0;
  logic [NREQ-1:0]         req_ready,  req_ready0;
  logic [WIDTH-1:0]        xfer_data,  xfer_data0;
  logic [1:0]              xfer_id,    xfer_id0;
  logic                    xfer_active, xfer_active0;
  logic                    busy,       busy0;

  cdc_xfer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .xfer_data(xfer_data), .xfer_id(xfer_id),
    .xfer_active(xfer_active), .busy(busy)
  );

  cdc_xfer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .xfer_data(xfer_data0), .xfer_id(xfer_id0),
    .xfer_active(xfer_active0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // requester-side state driven by the bench
  logic [NREQ-1:0]  vld;
  logic [WIDTH-1:0] dat [NREQ];
  logic [NREQ-1:0]  v0;
  bit               refill = 0;
  bit               rnd = 0;

  // reference model: remembers the last grant and when the channel frees up
  int         cyc = 0;
  int         free_at = 0;
  int         gcyc = 0;
  int         ptr = 0;
  bit         has = 0;
  logic [31:0] e_data = '0;
  int         e_id = 0;

  // observed grant logs and activity counters
  int gl_id[$], gl_cyc[$], l0_id[$], l0_cyc[$];
  int act_cnt, busy_cnt, rdy_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cycle();
    int g, d;
    logic [NREQ-1:0] exp_rdy;
    req_valid  = vld;
    req_valid0 = v0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    @(negedge clk);
    g = -1;
    if (!reset && cyc >= free_at) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && vld[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      end
    end
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    if (req_ready != 0) begin gl_id.push_back(oh_idx(req_ready)); gl_cyc.push_back(cyc); rdy_cnt++; end
    if (req_ready0 != 0) begin l0_id.push_back(oh_idx(req_ready0)); l0_cyc.push_back(cyc); end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      ptr = 0; has = 0; free_at = cyc; e_data = '0; e_id = 0;
    end else if (g >= 0) begin
      ptr = (g + 1) % NREQ; e_data = dat[g]; e_id = g; gcyc = cyc - 1; has = 1;
      free_at = gcyc + 1 + HOLD + GAP;
      vld[g] = refill;
      if (refill) dat[g] = $urandom;
    end
    d = cyc - gcyc;
    chk("xfer_active", xfer_active, has && d >= 1 && d <= HOLD);
    chk("busy", busy, has && d >= 1 && d <= HOLD + GAP);
    chk("xfer_data", xfer_data, e_data);
    chk("xfer_id", xfer_id, e_id);
    act_cnt  += int'(xfer_active);
    busy_cnt += int'(busy);
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 7) == 0) begin vld[i] = 1'b1; dat[i] = $urandom; end
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && cyc < free_at; n++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    vld = '1;
    v0 = '0;
    for (int i = 0; i < NREQ; i++) dat[i] = 32'h1000 + i;
    for (int i = 0; i < NREQ; i++) req_data0[i*WIDTH +: WIDTH] = 32'hA0 + i;
    req_valid = vld; req_valid0 = v0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    @(posedge clk);
    #1;

    // 1: reset held with every requester valid
    repeat (3) cycle();
    chk("t1_active", xfer_active, 1'b0);
    chk("t1_data", xfer_data, 32'h0);
    chk("t1_id", xfer_id, 2'd0);
    vld = '0;
    reset = 1'b0;

    // 2: single requester 2, hold and busy lengths, then the next grant
    refill = 1;
    vld = 4'b0100;
    dat[2] = 32'hDEADBEEF;
    gl_id.delete(); gl_cyc.delete();
    act_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    cycle();
    chk("t2_data", xfer_data, 32'hDEADBEEF);
    chk("t2_id", xfer_id, 2'd2);
    repeat (18) cycle();
    chk("t2_active_cycles", act_cnt, HOLD);
    chk("t2_busy_cycles", busy_cnt, HOLD + GAP);
    chk("t2_ready_cycles", rdy_cnt, 1);
    cycle();
    chk("t2_grants", gl_id.size(), 2);
    if (gl_id.size() >= 2) chk("t2_interval", gl_cyc[1] - gl_cyc[0], 1 + HOLD + GAP);

    // 3: all requesters continuously valid from a fresh pointer
    reset = 1'b1;
    vld = '0;
    repeat (2) cycle();
    reset = 1'b0;
    vld = '1;
    gl_id.delete(); gl_cyc.delete();
    repeat (6 * (1 + HOLD + GAP)) cycle();
    chk("t3_grants", gl_id.size(), 6);
    for (int k = 0; k < 6 && k < gl_id.size(); k++) begin
      chk("t3_id", gl_id[k], k % NREQ);
      if (k > 0) chk("t3_interval", gl_cyc[k] - gl_cyc[k-1], 1 + HOLD + GAP);
    end

    // 4: pointer wrap after a grant to the last requester
    refill = 0;
    vld = '0;
    wait_idle();
    vld = 4'b1000;
    gl_id.delete(); gl_cyc.delete();
    cycle();
    vld = 4'b1001;
    repeat (40) cycle();
    chk("t4_grants", gl_id.size(), 3);
    if (gl_id.size() >= 3) begin
      chk("t4_id0", gl_id[0], 3);
      chk("t4_id1", gl_id[1], 0);
      chk("t4_id2", gl_id[2], 3);
    end

    // 5: reset in the middle of HOLD drops the word and rewinds the pointer
    vld = '0;
    wait_idle();
    vld = 4'b0100;
    dat[2] = $urandom;
    cycle();
    vld[1] = 1'b1; vld[3] = 1'b1;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    chk("t5_active", xfer_active, 1'b0);
    chk("t5_busy", busy, 1'b0);
    reset = 1'b0;
    gl_id.delete(); gl_cyc.delete();
    cycle();
    chk("t5_grants", gl_id.size(), 1);
    if (gl_id.size() >= 1) chk("t5_first", gl_id[0], 1);

    // random traffic on the main instance; GAP_CYCLES=0 instance sees 1001
    rnd = 1;
    v0 = 4'b1001;
    l0_id.delete(); l0_cyc.delete();
    repeat (600) cycle();
    chk("g0_enough", l0_id.size() >= 3, 1'b1);
    if (l0_id.size() >= 3) begin
      chk("g0_id0", l0_id[0], 0);
      chk("g0_id1", l0_id[1], 3);
      chk("g0_id2", l0_id[2], 0);
      chk("g0_period1", l0_cyc[1] - l0_cyc[0], 1 + HOLD);
      chk("g0_period2", l0_cyc[2] - l0_cyc[1], 1 + HOLD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
